pipe_skid: RTL and testbench

PIPE_SKID -- requirements
Module: pipe_skid

---
 rtl/pipe_skid.sv | 141 ++++++++++++++
 tb/tb_pipe_skid.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid.sv
// Two-entry valid/ready register slice (main + skid) with an optional stall counter.
// Define PIPE_SKID_STALL_CNT_EN to build the stall counter; otherwise stall_cnt reads 0.
module pipe_skid #(
  parameter int unsigned    DW     = 32,
  parameter logic [DW-1:0]  RST_VL = {DW{1'b0}},
  parameter int unsigned    CW     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [DW-1:0] in_dat,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_dat,
  output logic [CW-1:0] stall_cnt,
  input  logic          stall_clr
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nx_s;
  logic          in_rdy_r;
  logic          out_vld_r;
  logic [DW-1:0] main_r;
  logic [DW-1:0] skid_r;
  logic          in_fire_s;
  logic          load_main_s;
  logic          load_skid_s;
  logic          skid_to_main_s;

  // Only a beat presented while in_rdy is high is a real transfer.
  assign in_fire_s = in_vld & in_rdy_r;

  // Next-state and register-load decode.
  always_comb begin
    state_nx_s     = state_r;
    load_main_s    = 1'b0;
    load_skid_s    = 1'b0;
    skid_to_main_s = 1'b0;
    case (state_r)
      EMPTY: begin
        if (in_fire_s) begin
          load_main_s = 1'b1;
          state_nx_s  = ONE;
        end else begin
          state_nx_s  = EMPTY;
        end
      end
      ONE: begin
        if (in_fire_s && out_rdy) begin
          load_main_s = 1'b1;
          state_nx_s  = ONE;
        end else if (in_fire_s) begin
          load_skid_s = 1'b1;
          state_nx_s  = FULL;
        end else if (out_rdy) begin
          state_nx_s  = EMPTY;
        end else begin
          state_nx_s  = ONE;
        end
      end
      FULL: begin
        if (out_rdy) begin
          skid_to_main_s = 1'b1;
          state_nx_s     = ONE;
        end else begin
          state_nx_s     = FULL;
        end
      end
      default: begin
        state_nx_s = EMPTY;
      end
    endcase
  end

  // State and handshake flags; both flags are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= EMPTY;
      in_rdy_r  <= 1'b0;
      out_vld_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      in_rdy_r  <= (state_nx_s != FULL);
      out_vld_r <= (state_nx_s != EMPTY);
    end
  end

  // Main register feeds out_dat; it holds whenever nothing loads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_r <= RST_VL;
    end else if (load_main_s) begin
      main_r <= in_dat;
    end else if (skid_to_main_s) begin
      main_r <= skid_r;
    end
  end

  // Skid register catches the beat accepted while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_r <= RST_VL;
    end else if (load_skid_s) begin
      skid_r <= in_dat;
    end
  end

  assign in_rdy  = in_rdy_r;
  assign out_vld = out_vld_r;
  assign out_dat = main_r;

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [CW-1:0] stall_cnt_r;

  // Saturating stall counter; clear wins over a simultaneous stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {CW{1'b0}};
    end else if (stall_clr) begin
      stall_cnt_r <= {CW{1'b0}};
    end else if (out_vld_r && !out_rdy && (stall_cnt_r != {CW{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  logic unused_stall_clr_s;

  assign unused_stall_clr_s = stall_clr;
  assign stall_cnt          = {CW{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_skid.sv
// Directed, table-driven bench for pipe_skid plus hand-written reset,
// saturation and mid-operation reset sequences.
module tb_pipe_skid;

`ifdef PIPE_SKID_STALL_CNT_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  typedef struct {
    logic        in_vld;
    logic [31:0] in_dat;
    logic        out_rdy;
    logic        stall_clr;
    logic        exp_in_rdy;
    logic        exp_out_vld;
    logic        chk_dat;
    logic [31:0] exp_dat;
    logic [15:0] exp_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_vld, in_rdy, out_vld, out_rdy, stall_clr;
  logic [31:0] in_dat, out_dat;
  logic [15:0] stall_cnt;

  logic        in_vld2, in_rdy2, out_vld2, out_rdy2, stall_clr2;
  logic [7:0]  in_dat2, out_dat2;
  logic [3:0]  stall_cnt2;

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  pipe_skid u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat),
    .stall_cnt(stall_cnt), .stall_clr(stall_clr)
  );

  pipe_skid #(.DW(8), .RST_VL(8'h00), .CW(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld2), .in_rdy(in_rdy2), .in_dat(in_dat2),
    .out_vld(out_vld2), .out_rdy(out_rdy2), .out_dat(out_dat2),
    .stall_cnt(stall_cnt2), .stall_clr(stall_clr2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [31:0] id, input logic ordy, input logic clr,
                     input logic e_irdy, input logic e_ovld, input logic cd,
                     input logic [31:0] e_dat, input logic [15:0] e_cnt);
    vec_t v;
    v.in_vld = iv; v.in_dat = id; v.out_rdy = ordy; v.stall_clr = clr;
    v.exp_in_rdy = e_irdy; v.exp_out_vld = e_ovld; v.chk_dat = cd;
    v.exp_dat = e_dat; v.exp_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t v;
    logic [31:0] exp_c;

    // Expected state is the one seen just after the edge that applied the row.
    // First edge after release: in_rdy was still 0, so DEAD must not be taken.
    add(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 16'd0);
    add(1'b1, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA5A5_A5A5, 16'd0);
    add(1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA5A5_A5A5, 16'd0);
    for (int i = 0; i < 8; i++)
      add(1'b1, 32'(i), 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'(i), 16'd0);
    add(1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 16'd0);
    // Backpressure fill, 0x33 refused while FULL, then drain in order.
    add(1'b1, 32'h0000_0011, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0011, 16'd0);
    add(1'b1, 32'h0000_0022, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0011, 16'd1);
    add(1'b1, 32'h0000_0033, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0011, 16'd2);
    add(1'b1, 32'h0000_0033, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0022, 16'd2);
    add(1'b1, 32'h0000_0033, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0033, 16'd2);
    add(1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 16'd2);
    // Stall counting: clear, 5 stalls, clear during a stall, one more stall.
    add(1'b1, 32'h0000_0044, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0044, 16'd0);
    for (int i = 1; i <= 5; i++)
      add(1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0044, 16'(i));
    add(1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0044, 16'd0);
    add(1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0044, 16'd1);
    add(1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0044, 16'd1);

    rst_n = 1'b0;
    in_vld = 1'b0; in_dat = 32'h0; out_rdy = 1'b0; stall_clr = 1'b0;
    in_vld2 = 1'b0; in_dat2 = 8'h00; out_rdy2 = 1'b1; stall_clr2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst out_vld", {31'd0, out_vld}, 32'd0);
    check("rst in_rdy", {31'd0, in_rdy}, 32'd0);
    check("rst out_dat", out_dat, 32'h0000_0000);
    check("rst stall_cnt", {16'd0, stall_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      in_vld = v.in_vld; in_dat = v.in_dat; out_rdy = v.out_rdy; stall_clr = v.stall_clr;
      @(posedge clk);
      #1;
      check($sformatf("row%0d in_rdy", i), {31'd0, in_rdy}, {31'd0, v.exp_in_rdy});
      check($sformatf("row%0d out_vld", i), {31'd0, out_vld}, {31'd0, v.exp_out_vld});
      if (v.chk_dat)
        check($sformatf("row%0d out_dat", i), out_dat, v.exp_dat);
      exp_c = STALL_EN ? {16'd0, v.exp_cnt} : 32'd0;
      check($sformatf("row%0d stall_cnt", i), {16'd0, stall_cnt}, exp_c);
    end
    in_vld = 1'b0; stall_clr = 1'b0; out_rdy = 1'b1;

    // CW=4 instance: load one beat, then stall 20 cycles; counter saturates at 15.
    in_vld2 = 1'b1; in_dat2 = 8'h5A; out_rdy2 = 1'b0;
    @(posedge clk);
    #1;
    in_vld2 = 1'b0;
    check("sat load out_vld", {31'd0, out_vld2}, 32'd1);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      exp_c = STALL_EN ? ((k < 15) ? 32'(k) : 32'd15) : 32'd0;
      check($sformatf("sat cnt k%0d", k), {28'd0, stall_cnt2}, exp_c);
    end
    check("sat hold out_dat", {24'd0, out_dat2}, 32'h0000_005A);

    // Fill to FULL with 0x11/0x22, then reset between edges.
    in_vld = 1'b1; in_dat = 32'h0000_0011; out_rdy = 1'b0;
    @(posedge clk);
    #1;
    in_dat = 32'h0000_0022;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    check("pre-rst in_rdy", {31'd0, in_rdy}, 32'd0);
    check("pre-rst out_dat", out_dat, 32'h0000_0011);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst out_vld", {31'd0, out_vld}, 32'd0);
    check("midrst in_rdy", {31'd0, in_rdy}, 32'd0);
    check("midrst out_dat", out_dat, 32'h0000_0000);
    check("midrst stall_cnt", {16'd0, stall_cnt}, 32'd0);
    check("midrst dut4 out_vld", {31'd0, out_vld2}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("postrst k%0d out_vld", k), {31'd0, out_vld}, 32'd0);
    end
    check("postrst in_rdy", {31'd0, in_rdy}, 32'd1);
    in_vld = 1'b1; in_dat = 32'h0000_0077;
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    check("postrst beat vld", {31'd0, out_vld}, 32'd1);
    check("postrst beat dat", out_dat, 32'h0000_0077);
    @(posedge clk);
    #1;
    check("postrst drained", {31'd0, out_vld}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
